// File: rtl/axi_lite_traffic_checker.sv
// axi_lite_traffic_checker
//   AXI4-Lite master that writes, read-checks or writes-then-reads-back a
//   window of 2^DEPTH_LOG2 words on a slave. Data is an address-derived
//   pattern, so no preload file is needed. The block counts matches,
//   mismatches and error responses, and keeps the address of the first
//   failure of each pass.
//
// Ports
//   ACLK, ARESET           clock, synchronous active-high reset
//   start/mode/addr_random/num_txn
//                          pass control, sampled only while idle
//                          mode: 0 write, 1 read, 2 write-read, 3 ignored
//   busy, done             busy spans the pass; done pulses in its last cycle
//   match_count, mismatch_count, resp_err_count
//                          saturating result counters
//   first_err_addr, err_seen
//                          address of the first failure, and its valid flag
//   aw*/w*/b*/ar*/r*       AXI4-Lite master channels
module axi_lite_traffic_checker #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    addr_random,
    input  logic [CNT_WIDTH-1:0]    num_txn,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    match_count,
    output logic [CNT_WIDTH-1:0]    mismatch_count,
    output logic [CNT_WIDTH-1:0]    resp_err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic                    err_seen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp
);

    localparam int          BSHIFT     = $clog2(DATA_WIDTH / 8);
    localparam logic [15:0] LFSR_INIT  = 16'hACE1;
    localparam logic [1:0]  MODE_WRITE = 2'd0;
    localparam logic [1:0]  MODE_READ  = 2'd1;
    localparam logic [1:0]  MODE_WR_RD = 2'd2;
    localparam logic [1:0]  MODE_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_AW_W, S_B_WAIT, S_AR, S_R_WAIT, S_DONE
    } state_t;

    state_t                 state;
    logic [1:0]             mode_r;
    logic                   rnd_r;
    logic [CNT_WIDTH-1:0]   n_r;
    logic [CNT_WIDTH-1:0]   txn_cnt;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [15:0]            lfsr;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [DEPTH_LOG2-1:0] i);
        return ADDR_WIDTH'(i) << BSHIFT;
    endfunction

    // 64-bit words carry the inverted pattern in the upper half.
    function automatic logic [DATA_WIDTH-1:0] pat_of(input logic [DEPTH_LOG2-1:0] i);
        logic [31:0] p;
        logic [63:0] full;
        p    = SEED ^ (32'(i) * 32'h9E3779B1);
        full = {~p, p};
        return full[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [15:0]           lfsr_nxt;
    logic [DEPTH_LOG2-1:0] idx_nxt;
    logic [DEPTH_LOG2-1:0] idx_first;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  last_txn;
    logic                  txn_end;
    logic                  rec_err;

    assign lfsr_nxt  = lfsr_step(lfsr);
    assign idx_nxt   = rnd_r ? lfsr_nxt[DEPTH_LOG2-1:0] : idx + 1'b1;
    assign idx_first = addr_random ? LFSR_INIT[DEPTH_LOG2-1:0] : '0;
    assign cnt_nxt   = txn_cnt + 1'b1;
    assign last_txn  = (cnt_nxt == n_r);

    // A transaction retires on B for pure writes and on R otherwise;
    // a write-read pass turns around to AR after its B instead.
    assign txn_end = (state == S_B_WAIT && bvalid && mode_r == MODE_WRITE) ||
                     (state == S_R_WAIT && rvalid);
    assign rec_err = (state == S_B_WAIT && bvalid && bresp != 2'b00) ||
                     (state == S_R_WAIT && rvalid &&
                      (rresp != 2'b00 || rdata != pat_of(idx)));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state          <= S_IDLE;
            mode_r         <= MODE_WRITE;
            rnd_r          <= 1'b0;
            n_r            <= '0;
            txn_cnt        <= '0;
            idx            <= '0;
            lfsr           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            resp_err_count <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            awvalid        <= 1'b0;
            awaddr         <= '0;
            awprot         <= 3'b000;
            wvalid         <= 1'b0;
            wdata          <= '0;
            wstrb          <= '0;
            bready         <= 1'b0;
            arvalid        <= 1'b0;
            araddr         <= '0;
            arprot         <= 3'b000;
            rready         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && mode != MODE_RSVD) begin
                        mode_r         <= mode;
                        rnd_r          <= addr_random;
                        n_r            <= num_txn;
                        txn_cnt        <= '0;
                        idx            <= idx_first;
                        lfsr           <= LFSR_INIT;
                        busy           <= 1'b1;
                        match_count    <= '0;
                        mismatch_count <= '0;
                        resp_err_count <= '0;
                        first_err_addr <= '0;
                        err_seen       <= 1'b0;
                        wstrb          <= '1;
                        if (num_txn == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (mode == MODE_READ) begin
                            state   <= S_AR;
                            arvalid <= 1'b1;
                            araddr  <= addr_of(idx_first);
                        end else begin
                            state   <= S_AW_W;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= addr_of(idx_first);
                            wdata   <= pat_of(idx_first);
                        end
                    end
                end
                S_AW_W: begin
                    // AW and W retire independently; a low valid here
                    // means that channel already handshook.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state  <= S_B_WAIT;
                        bready <= 1'b1;
                    end
                end
                S_B_WAIT: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00) resp_err_count <= sat_inc(resp_err_count);
                        if (mode_r == MODE_WR_RD) begin
                            state   <= S_AR;
                            arvalid <= 1'b1;
                            araddr  <= addr_of(idx);
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R_WAIT;
                    end
                end
                S_R_WAIT: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rresp != 2'b00)
                            resp_err_count <= sat_inc(resp_err_count);
                        else if (rdata == pat_of(idx))
                            match_count <= sat_inc(match_count);
                        else
                            mismatch_count <= sat_inc(mismatch_count);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (rec_err && !err_seen) begin
                err_seen       <= 1'b1;
                first_err_addr <= addr_of(idx);
            end

            // Advance to the next index and launch its first phase.
            if (txn_end) begin
                txn_cnt <= cnt_nxt;
                lfsr    <= lfsr_nxt;
                idx     <= idx_nxt;
                if (last_txn) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else if (mode_r == MODE_READ) begin
                    state   <= S_AR;
                    arvalid <= 1'b1;
                    araddr  <= addr_of(idx_nxt);
                end else begin
                    state   <= S_AW_W;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                    awaddr  <= addr_of(idx_nxt);
                    wdata   <= pat_of(idx_nxt);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_traffic_checker.sv
// Scoreboard bench for axi_lite_traffic_checker: a memory slave model with
// optional back-pressure, corruption and SLVERR injection; expectations are
// queued by the driver and consumed by a negedge monitor.
module tb_axi_lite_traffic_checker;
    localparam int          AW = 16;
    localparam int          DW = 32;
    localparam int          DL = 10;
    localparam int          CW = 16;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    typedef struct {
        int          match;
        int          mism;
        int          rerr;
        logic        seen;
        logic [15:0] fea;
        int          lat;
        int          nb;
    } res_t;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic addr_random = 1'b0;
    logic [CW-1:0] num_txn = '0;
    logic busy, done, err_seen;
    logic [CW-1:0] match_count, mismatch_count, resp_err_count;
    logic [AW-1:0] first_err_addr, awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [2:0] awprot, arprot;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0] bresp, rresp;

    always #5 ACLK = ~ACLK;

    axi_lite_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW), .SEED(SEED)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode),
        .addr_random(addr_random), .num_txn(num_txn), .busy(busy), .done(done),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .resp_err_count(resp_err_count), .first_err_addr(first_err_addr),
        .err_seen(err_seen), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awprot(awprot), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, no expectation queued (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] pat(input int i);
        return SEED ^ (32'(i) * 32'h9E3779B1);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    logic bp_en = 1'b0;
    logic ar_hold = 1'b0;
    int corrupt_idx = -1;
    int slverr_idx = -1;
    logic aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [31:0] w_d;
    logic ga, gw;
    logic [AW-1:0] sa;
    logic [31:0] sd;
    int ri;

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    always @(posedge ACLK) begin
        if (ARESET) begin
            awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00;
            rdata <= '0; aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
        end else begin
            awready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            arready <= ar_hold ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
            ga = aw_got; sa = aw_a; gw = w_got; sd = w_d;
            if (awvalid && awready) begin ga = 1'b1; sa = awaddr; end
            if (wvalid && wready)   begin gw = 1'b1; sd = wdata;  end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ga && gw) begin
                mem[sa[11:2]] <= sd;
                bvalid <= 1'b1;
                bresp  <= 2'b00;
                ga = 1'b0;
                gw = 1'b0;
            end
            aw_got <= ga; aw_a <= sa; w_got <= gw; w_d <= sd;
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                ri = int'(araddr[11:2]);
                rvalid <= 1'b1;
                rdata  <= mem[ri] ^ ((ri == corrupt_idx) ? 32'h1 : 32'h0);
                rresp  <= (ri == slverr_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_aw [$];
    logic [31:0] exp_w [$];
    logic [15:0] exp_ar [$];
    res_t exp_res [$];

    logic pa, pw, pr;
    logic [AW-1:0] pa_addr, pr_addr;
    logic [DW-1:0] pw_data;
    int b_cnt;
    res_t mr;

    always @(negedge ACLK) begin
        if (ARESET) begin
            pa <= 1'b0; pw <= 1'b0; pr <= 1'b0; b_cnt <= 0;
        end else begin
            if (pa) chk("aw_stable", {awvalid, awaddr}, {1'b1, pa_addr});
            if (pw) chk("w_stable", {wvalid, wdata}, {1'b1, pw_data});
            if (pr) chk("ar_stable", {arvalid, araddr}, {1'b1, pr_addr});
            pa <= awvalid && !awready; pa_addr <= awaddr;
            pw <= wvalid && !wready;   pw_data <= wdata;
            pr <= arvalid && !arready; pr_addr <= araddr;

            if (awvalid && awready) begin
                if (exp_aw.size() == 0) miss("aw_extra");
                else chk("awaddr", {awprot, awaddr}, {3'b000, exp_aw.pop_front()});
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) miss("w_extra");
                else chk("wdata", {wstrb, wdata}, {4'hF, exp_w.pop_front()});
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) miss("ar_extra");
                else chk("araddr", {arprot, araddr}, {3'b000, exp_ar.pop_front()});
            end
            if (done) begin
                if (exp_res.size() == 0) miss("done_extra");
                else begin
                    mr = exp_res.pop_front();
                    chk("match_count", match_count, 64'(mr.match));
                    chk("mismatch_count", mismatch_count, 64'(mr.mism));
                    chk("resp_err_count", resp_err_count, 64'(mr.rerr));
                    chk("err_seen", err_seen, mr.seen);
                    chk("first_err_addr", first_err_addr, mr.fea);
                    chk("b_count", 64'(b_cnt), 64'(mr.nb));
                    chk("busy_at_done", busy, 1'b1);
                    if (mr.lat >= 0) chk("done_cycle", 64'(cyc), 64'(mr.lat));
                end
                b_cnt <= 0;
            end else if (bvalid && bready) begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic res_t mk(input int m, input int mm, input int re, input logic s,
                                input logic [15:0] f, input int nb);
        res_t r;
        r.match = m; r.mism = mm; r.rerr = re; r.seen = s; r.fea = f; r.lat = -1; r.nb = nb;
        return r;
    endfunction

    task automatic run_pass(input logic [1:0] m, input logic rnd, input int n,
                            input logic auto_exp, input logic lat_chk,
                            input res_t r_in, input int budget);
        res_t r;
        logic [15:0] l;
        int ix;
        bit got;
        r = r_in;
        l = 16'hACE1;
        if (auto_exp) begin
            for (int k = 0; k < n; k++) begin
                ix = rnd ? int'(l[9:0]) : (k % 1024);
                if (m != 2'd1) begin
                    exp_aw.push_back(16'(ix * 4));
                    exp_w.push_back(pat(ix));
                end
                if (m != 2'd0) exp_ar.push_back(16'(ix * 4));
                l = lfsr_step(l);
            end
        end
        step();
        r.lat = lat_chk ? cyc + ((m == 2'd2) ? 4 * n : 2 * n) + 1 : -1;
        exp_res.push_back(r);
        mode = m; addr_random = rnd; num_txn = CW'(n); start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            if (done) got = 1;
            else step();
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL pass_timeout: mode %0d n %0d got no done within %0d cycles", m, n, budget);
        end
    endtask

    logic [15:0] hand_a [4] = '{16'h0, 16'h4, 16'h8, 16'hC};
    logic [31:0] hand_w [4] = '{32'hACE12468, 32'h32D65DD9, 32'h908FD70A, 32'h7647497B};

    initial begin
        int bc;
        bit got;
        repeat (3) step();
        chk("rst_ctl", {busy, done, err_seen, awvalid, wvalid, bready, arvalid, rready}, 8'h0);
        chk("rst_cnt", {match_count, mismatch_count, resp_err_count}, 48'h0);
        chk("rst_addr", {awaddr, araddr, first_err_addr}, 48'h0);
        chk("rst_data_prot", {wdata, awprot, arprot}, 38'h0);
        ARESET = 1'b0;
        repeat (2) step();

        // sequential write of four words, hand-computed pattern
        for (int i = 0; i < 4; i++) begin
            exp_aw.push_back(hand_a[i]);
            exp_w.push_back(hand_w[i]);
        end
        run_pass(2'd0, 1'b0, 4, 1'b0, 1'b1, mk(0, 0, 0, 1'b0, 16'h0, 4), 50);
        // read them back
        run_pass(2'd1, 1'b0, 4, 1'b1, 1'b1, mk(4, 0, 0, 1'b0, 16'h0, 0), 50);

        // write-read, random addresses, random back-pressure
        bp_en = 1'b1;
        run_pass(2'd2, 1'b1, 1024, 1'b1, 1'b0, mk(1024, 0, 0, 1'b0, 16'h0, 1024), 30000);
        bp_en = 1'b0;

        // corruption on idx 5, SLVERR on idx 7
        run_pass(2'd0, 1'b0, 8, 1'b1, 1'b1, mk(0, 0, 0, 1'b0, 16'h0, 8), 100);
        corrupt_idx = 5; slverr_idx = 7;
        run_pass(2'd1, 1'b0, 8, 1'b1, 1'b1, mk(6, 1, 1, 1'b1, 16'h14, 0), 100);
        corrupt_idx = -1; slverr_idx = -1;

        // sequential wrap past the top of the window
        run_pass(2'd0, 1'b0, 1026, 1'b1, 1'b1, mk(0, 0, 0, 1'b0, 16'h0, 1026), 3000);

        // reserved mode is ignored
        step();
        mode = 2'd3; num_txn = CW'(4); start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("mode3_idle", {busy, done, awvalid, arvalid}, 4'h0);
            step();
        end

        // reset while an AR is stalled
        ar_hold = 1'b1;
        mode = 2'd1; addr_random = 1'b1; num_txn = CW'(4); start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (arvalid) got = 1;
            else step();
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL hold_arvalid: arvalid never rose");
        end
        ARESET = 1'b1;
        step();
        chk("mid_rst_ctl", {busy, done, err_seen, awvalid, wvalid, bready, arvalid, rready}, 8'h0);
        chk("mid_rst_cnt", {match_count, mismatch_count, resp_err_count}, 48'h0);
        chk("mid_rst_addr", {awaddr, araddr, first_err_addr}, 48'h0);
        chk("mid_rst_data", {wdata, awprot, arprot}, 38'h0);
        step();
        ARESET = 1'b0;
        ar_hold = 1'b0;
        exp_ar.delete();
        exp_res.delete();
        repeat (2) step();

        // empty pass: done in cycle 1, busy for exactly one cycle
        exp_res.push_back(mk(0, 0, 0, 1'b0, 16'h0, 0));
        exp_res[0].lat = cyc + 1;
        mode = 2'd0; addr_random = 1'b0; num_txn = '0; start = 1'b1;
        step();
        start = 1'b0;
        bc = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy) bc++;
            step();
        end
        chk("n0_busy_cycles", 64'(bc), 64'd1);

        chk("aw_q_left", 64'(exp_aw.size()), 64'd0);
        chk("w_q_left", 64'(exp_w.size()), 64'd0);
        chk("ar_q_left", 64'(exp_ar.size()), 64'd0);
        chk("res_q_left", 64'(exp_res.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
